// File: rtl/pll_lock_reset_seq_pkg.sv
// Shared types and constants for the PLL lock / reset sequencer.
package pll_lock_reset_seq_pkg;

  // Sequencer states:
  //   state     | meaning
  //   ST_IDLE   | both resets asserted, waiting for go
  //   ST_FILTER | go high, counting LOCK_FILTER stable cycles
  //   ST_STAGE1 | peripherals released, counting STAGE_DELAY cycles
  //   ST_RUN    | both resets released, LOCK_STABLE high
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILTER = 2'd1,
    ST_STAGE1 = 2'd2,
    ST_RUN    = 2'd3
  } seq_state_e;

  localparam int LOSS_CNT_W = 8;

  // Saturating increment for the lock-loss counter.
  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    logic [LOSS_CNT_W-1:0] one;
    one = {{(LOSS_CNT_W-1){1'b0}}, 1'b1};
    return (&v) ? v : (v + one);
  endfunction

endpackage

// File: rtl/pll_lock_reset_seq_rst_bit_sync.sv
// rst_bit_sync: SYNC_STAGES-deep flop chain bringing one asynchronous bit
// into the CLK domain. The synchronous reset clears the whole chain to 0 so
// a freshly reset block never sees a stale "lock" or "button released".
module pll_lock_reset_seq_rst_bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw input in at bit 0; the oldest sample leaves at the top.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  // Chain registers, cleared by the block reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL lock qualifier and two-stage reset release sequencer.
// Synced PLL lock, synced board reset and INIT_DONE must all be high (go) for
// LOCK_FILTER consecutive cycles before PERIPH_RESET_N releases; FABRIC_RESET_N
// follows STAGE_DELAY cycles later. Any drop of go returns to IDLE at once.
// Optional build macro PLL_LOCK_LOSS_CNT_EN enables the saturating count of
// lock losses seen in RUN; without it LOCK_LOSS_CNT is tied to zero.
module pll_lock_reset_seq
  import pll_lock_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 1024,
  parameter int STAGE_DELAY = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PLL_LOCK,
  input  logic                  EXT_RST_N,
  input  logic                  INIT_DONE,
  output logic                  PERIPH_RESET_N,
  output logic                  FABRIC_RESET_N,
  output logic                  LOCK_STABLE,
  output logic [LOSS_CNT_W-1:0] LOCK_LOSS_CNT
);

  localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic lock_s;
  logic ext_s;
  logic go;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             periph_q, periph_d;
  logic             fabric_q, fabric_d;
  logic             stable_q, stable_d;

  pll_lock_reset_seq_rst_bit_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i   (CLK),
    .reset_i (RESET),
    .d_i     (PLL_LOCK),
    .q_o     (lock_s)
  );

  pll_lock_reset_seq_rst_bit_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ext_sync (
    .clk_i   (CLK),
    .reset_i (RESET),
    .d_i     (EXT_RST_N),
    .q_o     (ext_s)
  );

  assign go = lock_s & ext_s & INIT_DONE;

  // Next state, delay counter and the registered outputs derived from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (go) begin
          state_d = ST_FILTER;
        end
      end

      ST_FILTER: begin
        if (!go) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == FILTER_LAST) begin
          state_d = ST_STAGE1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_STAGE1: begin
        if (!go) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == STAGE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RUN: begin
        cnt_d = '0;
        if (!go) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the state being entered so they move on the transition edge.
    periph_d = (state_d == ST_STAGE1) || (state_d == ST_RUN);
    fabric_d = (state_d == ST_RUN);
    stable_d = (state_d == ST_RUN);
  end

  // State, counter and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      fabric_q <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      fabric_q <= fabric_d;
      stable_q <= stable_d;
    end
  end

  assign PERIPH_RESET_N = periph_q;
  assign FABRIC_RESET_N = fabric_q;
  assign LOCK_STABLE    = stable_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  // Count RUN exits caused by the synced lock dropping; a simultaneous board
  // reset still counts once, while board reset or INIT_DONE alone never count.
  always_comb begin
    loss_d = loss_q;
    if ((state_q == ST_RUN) && !lock_s) begin
      loss_d = sat_inc(loss_q);
    end
  end

  // Loss counter register, cleared only by the block reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign LOCK_LOSS_CNT = loss_q;
`else
  assign LOCK_LOSS_CNT = '0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Self-checking bench for pll_lock_reset_seq with SYNC_STAGES=2,
// LOCK_FILTER=8, STAGE_DELAY=4. The reference model tracks how many
// consecutive edges have seen go high; release points fall out of that run
// length directly.
module tb_pll_lock_reset_seq;

  localparam int S  = 2;
  localparam int LF = 8;
  localparam int SD = 4;
  localparam int CW = 16;
  localparam int RUN_LEN = LF + SD + 1;

`ifdef PLL_LOCK_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       PLL_LOCK = 1'b0;
  logic       EXT_RST_N = 1'b1;
  logic       INIT_DONE = 1'b1;
  logic       PERIPH_RESET_N;
  logic       FABRIC_RESET_N;
  logic       LOCK_STABLE;
  logic [7:0] LOCK_LOSS_CNT;

  pll_lock_reset_seq #(
    .SYNC_STAGES (S),
    .LOCK_FILTER (LF),
    .STAGE_DELAY (SD),
    .CNT_W       (CW)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .PLL_LOCK       (PLL_LOCK),
    .EXT_RST_N      (EXT_RST_N),
    .INIT_DONE      (INIT_DONE),
    .PERIPH_RESET_N (PERIPH_RESET_N),
    .FABRIC_RESET_N (FABRIC_RESET_N),
    .LOCK_STABLE    (LOCK_STABLE),
    .LOCK_LOSS_CNT  (LOCK_LOSS_CNT)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference model: delay lines for the two async inputs, the length of the
  // current unbroken run of go edges, and the expected loss count.
  bit lq[$];
  bit eq[$];
  int r;
  int m_llc;

  task automatic model_clear();
    lq = {};
    eq = {};
    for (int i = 0; i < S; i++) begin
      lq.push_back(1'b0);
      eq.push_back(1'b0);
    end
    r = 0;
    m_llc = 0;
  endtask

  task automatic model_edge();
    bit ls, es, go;
    if (RESET) begin
      model_clear();
    end else begin
      ls = lq[0];
      es = eq[0];
      go = ls & es & (INIT_DONE === 1'b1);
      if (!go) begin
        if (CNT_EN && r >= RUN_LEN && !ls && m_llc < 255) m_llc++;
        r = 0;
      end else if (r < RUN_LEN) begin
        r++;
      end
      lq.push_back(PLL_LOCK === 1'b1);
      void'(lq.pop_front());
      eq.push_back(EXT_RST_N === 1'b1);
      void'(eq.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    chk("periph", PERIPH_RESET_N, (r >= LF + 1) ? 1 : 0);
    chk("fabric", FABRIC_RESET_N, (r >= RUN_LEN) ? 1 : 0);
    chk("stable", LOCK_STABLE, (r >= RUN_LEN) ? 1 : 0);
    chk("loss_cnt", LOCK_LOSS_CNT, m_llc);
  endtask

  function automatic logic out_sel(input int which);
    case (which)
      0:       return PERIPH_RESET_N;
      1:       return FABRIC_RESET_N;
      default: return LOCK_STABLE;
    endcase
  endfunction

  // Tick until the chosen output reaches val; n is the number of edges taken.
  task automatic edges_until(input int which, input logic val, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (out_sel(which) !== val && n < budget);
  endtask

  initial begin
    int n, n2, len;
    model_clear();

    RESET = 1'b1;
    repeat (5) tick();
    chk("reset_periph", PERIPH_RESET_N, 0);
    chk("reset_loss", LOCK_LOSS_CNT, 0);
    RESET = 1'b0;
    repeat (3) tick();

    // Power-up release timing.
    PLL_LOCK = 1'b1;
    edges_until(0, 1'b1, 100, n);
    chk("pwrup_periph_edge", n, 11);
    chk("pwrup_fabric_still_low", FABRIC_RESET_N, 0);
    edges_until(1, 1'b1, 100, n2);
    chk("pwrup_fabric_edge", n + n2, 15);
    chk("pwrup_stable", LOCK_STABLE, 1);

    // Lock loss from RUN.
    PLL_LOCK = 1'b0;
    edges_until(1, 1'b0, 50, n);
    chk("loss_edge", n, 3);
    chk("loss_periph", PERIPH_RESET_N, 0);
    chk("loss_cnt_one", LOCK_LOSS_CNT, CNT_EN ? 1 : 0);

    // Single-cycle lock glitch at edge 7 of the filter.
    PLL_LOCK = 1'b1;
    repeat (7) tick();
    PLL_LOCK = 1'b0;
    tick();
    PLL_LOCK = 1'b1;
    edges_until(0, 1'b1, 100, n);
    chk("glitch_release", n, 11);
    edges_until(1, 1'b1, 50, n);
    chk("glitch_fabric", n, 4);

    // Two-cycle board reset while running.
    EXT_RST_N = 1'b0;
    tick();
    tick();
    EXT_RST_N = 1'b1;
    edges_until(1, 1'b0, 50, n);
    chk("ext_assert_edge", n, 1);
    chk("ext_periph", PERIPH_RESET_N, 0);
    edges_until(1, 1'b1, 100, n2);
    chk("ext_resequence", n + n2, 15);
    chk("ext_loss_unchanged", LOCK_LOSS_CNT, CNT_EN ? 1 : 0);

    // INIT_DONE low holds everything in reset.
    INIT_DONE = 1'b0;
    repeat (40) tick();
    chk("init_low_periph", PERIPH_RESET_N, 0);
    chk("init_low_fabric", FABRIC_RESET_N, 0);
    chk("init_low_loss", LOCK_LOSS_CNT, CNT_EN ? 1 : 0);
    INIT_DONE = 1'b1;

    // 300 lock losses from RUN saturate the counter.
    for (int k = 0; k < 300; k++) begin
      PLL_LOCK = 1'b1;
      edges_until(1, 1'b1, 100, n);
      PLL_LOCK = 1'b0;
      edges_until(1, 1'b0, 50, n);
    end
    chk("loss_saturate", LOCK_LOSS_CNT, CNT_EN ? 255 : 0);

    // RESET while in STAGE1.
    PLL_LOCK = 1'b1;
    edges_until(0, 1'b1, 100, n);
    chk("stage1_fabric_low", FABRIC_RESET_N, 0);
    RESET = 1'b1;
    tick();
    chk("rst_stage1_periph", PERIPH_RESET_N, 0);
    chk("rst_stage1_loss", LOCK_LOSS_CNT, 0);
    RESET = 1'b0;

    // Randomized segments of held input levels.
    for (int seg = 0; seg < 150; seg++) begin
      PLL_LOCK  = ($urandom_range(0, 9) != 0);
      EXT_RST_N = ($urandom_range(0, 14) != 0);
      INIT_DONE = ($urandom_range(0, 19) != 0);
      RESET     = ($urandom_range(0, 29) == 0);
      len = $urandom_range(1, 30);
      repeat (len) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
